wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port. Shares it between the pipeline write-back stage (data/address from the WB and WR muxes) and the long-latency unit (mult/div) result stream.
- Pipeline has priority. Long-unit results wait in a small FIFO.
- A starvation counter forces a drain cycle and stalls the pipeline.
- Exports a pending-write check for the hazard unit.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, long-unit result FIFO entries (power of two, ≥2)
- MAX_DEFER, 4, consecutive pipeline wins over a non-empty FIFO before a forced drain

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- pipe_we  in  1  WB stage requests a register write this cycle
- pipe_addr  in  ADDR_W  WB destination (WR mux output)
- pipe_data  in  DATA_W  WB data (WB mux output)
- pipe_stall  out  1  pipeline must hold its WB stage this cycle
- lu_valid  in  1  long unit presents a result
- lu_addr  in  ADDR_W  result destination register
- lu_data  in  DATA_W  result data
- lu_ready  out  1  FIFO accepts the result this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  ADDR_W  register-file write address (registered)
- rf_data  out  DATA_W  register-file write data (registered)
- chk_addr  in  ADDR_W  register queried by the hazard unit
- chk_pending  out  1  a live FIFO entry targets chk_addr

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-high.
- On reset:
  - rf_we/rf_addr/rf_data = 0
  - FIFO empty; all entry live bits = 0
  - state = PIPE_PRI; defer_cnt = 0
- Combinational outputs after reset: pipe_stall = 0, lu_ready = 1.
- Reset mid-operation discards all queued results.
- Register $0:
  - pipe_we with pipe_addr = 0 is treated as no request.
  - An lu result with lu_addr = 0 completes the handshake but is not enqueued.
- lu_ready = (count < DEPTH), combinational and independent of lu_valid.
  - Transfer occurs when lu_valid && lu_ready; the entry is pushed at the tail with live = 1.
  - Push and pop in the same cycle leave count unchanged.
- Write latency: a grant in cycle N produces rf_we/rf_addr/rf_data in cycle N+1. rf_we = 0 in cycles with no grant; addr/data hold their last values.
- State PIPE_PRI:
  - pipe_stall = 0.
  - pipe request: grant pipe. If the FIFO is non-empty, defer_cnt += 1; otherwise defer_cnt = 0.
  - else if FIFO non-empty: pop head; rf_we = head.live; defer_cnt = 0.
  - Transition to DRAIN when defer_cnt reaches MAX_DEFER (the update of that cycle).
- State DRAIN:
  - pipe_stall = 1 combinationally; pipe_we is ignored. The pipeline holds its values and retries.
  - Pop head (rf_we = head.live); defer_cnt = 0; return to PIPE_PRI next cycle.
  - If the FIFO is empty on entry (cannot occur legally), return immediately with no write.
- WAW squash:
  - When the pipe is granted with address X, every FIFO entry with addr == X gets live cleared in the same edge.
  - An lu push to X in the same cycle is also stored with live = 0.
  - A squashed entry still pops in order and consumes a port cycle with rf_we = 0.
- chk_pending = 1 when chk_addr ≠ 0 and any occupied entry has live = 1 with addr == chk_addr. Combinational; the same-cycle push is not visible.
- FIFO pointers wrap modulo DEPTH. count is ADDR-independent, width clog2(DEPTH)+1.

Test Plan:
- Reset then pipe_we=1, pipe_addr=8, pipe_data=0xDEADBEEF -> next cycle rf_we=1, rf_addr=8, rf_data=0xDEADBEEF. pipe_addr=0 -> rf_we stays 0.
- lu_valid with lu_addr=3, data=0x11 while pipe idle -> accepted (lu_ready=1); chk_addr=3 gives chk_pending=1; write of 3/0x11 appears two cycles after the handshake; chk_pending then 0.
- Fill FIFO (addrs 4, 5) while pipe_we held high continuously -> lu_ready=0 with count=2; after 4 pipe grants pipe_stall=1 for one cycle and rf writes 4; then pipe resumes; defer restarts.
- Queue addr 7 (data 0xAA), then pipe writes addr 7 (data 0xBB) -> rf gets 7/0xBB; the later pop of the entry gives rf_we=0; chk_pending(7)=0 after squash.
- Simultaneous push to addr 9 and pipe grant to addr 9 -> entry stored dead; the final register value is the pipe data.
- Assert reset asynchronously (mid-clock) with 2 queued entries and DRAIN active -> outputs 0 immediately; lu_ready=1, pipe_stall=0; no queued write ever appears.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority; long-unit results queue in a small FIFO.
// Latency: a grant in cycle N drives rf_we/rf_addr/rf_data in cycle N+1. Backpressure: lu_ready while FIFO not full, pipe_stall in DRAIN.
module wb_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 2,
    parameter int MAX_DEFER = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_pending
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    typedef enum logic {
        PIPE_PRI = 1'b0,
        DRAIN    = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DEF_W-1:0]   defer_q, defer_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]   live_q, live_d;
    logic               rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]  rf_data_q, rf_data_d;

    logic fifo_empty, pipe_req, grant_pipe, pop, push, push_live;

    assign fifo_empty = (count_q == '0);
    assign lu_ready   = (count_q < CNT_W'(DEPTH));
    assign pipe_req   = pipe_we && (pipe_addr != '0);
    // Results for $0 complete the handshake but are never stored.
    assign push       = lu_valid && lu_ready && (lu_addr != '0);
    assign push_live  = !(grant_pipe && (lu_addr == pipe_addr));

    always_comb begin
        state_d    = state_q;
        defer_d    = defer_q;
        pipe_stall = 1'b0;
        grant_pipe = 1'b0;
        pop        = 1'b0;
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        case (state_q)
            PIPE_PRI: begin
                if (pipe_req) begin
                    grant_pipe = 1'b1;
                    rf_we_d    = 1'b1;
                    rf_addr_d  = pipe_addr;
                    rf_data_d  = pipe_data;
                    defer_d    = fifo_empty ? '0 : defer_q + DEF_W'(1);
                end else begin
                    pop     = !fifo_empty;
                    defer_d = '0;
                end
                if (defer_d == DEF_W'(MAX_DEFER)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                pipe_stall = 1'b1;
                pop        = !fifo_empty;
                defer_d    = '0;
                state_d    = PIPE_PRI;
            end
            default: state_d = PIPE_PRI;
        endcase
        // A squashed head still consumes the port cycle, but writes nothing.
        if (pop && live_q[rd_ptr_q]) begin
            rf_we_d   = 1'b1;
            rf_addr_d = addr_q[rd_ptr_q];
            rf_data_d = data_q[rd_ptr_q];
        end
    end

    // Live bits are cleared on pop, so a set bit always marks an occupied entry.
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant_pipe && (addr_q[i] == pipe_addr)) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = push_live;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        chk_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == chk_addr)) begin
                chk_pending = 1'b1;
            end
        end
        if (chk_addr == '0) begin
            chk_pending = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PIPE_PRI;
            defer_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            live_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            defer_q   <= defer_d;
            count_q   <= count_d;
            live_q    <= live_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            if (push) begin
                addr_q[wr_ptr_q] <= lu_addr;
                data_q[wr_ptr_q] <= lu_data;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: priority, forced drain, WAW squash, $0 handling and async reset.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [4:0]  chk_addr;
    logic        chk_pending;

    int n_chk  = 0;
    int n_fail = 0;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .MAX_DEFER(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .chk_addr(chk_addr), .chk_pending(chk_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, {31'd0, rf_we}, 32'd1);
        chk({tag, "_addr"}, {27'd0, rf_addr}, {27'd0, a});
        chk({tag, "_data"}, rf_data, d);
    endtask

    initial begin
        reset = 1'b1;
        pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0; chk_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_addr", {27'd0, rf_addr}, 32'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
        chk("rst_ready", {31'd0, lu_ready}, 32'd1);

        // Pipeline write, then a $0 write that must be ignored
        pipe_we = 1'b1; pipe_addr = 5'd8; pipe_data = 32'hDEADBEEF;
        tick;
        chk_rf("pipe8", 5'd8, 32'hDEADBEEF);
        pipe_addr = 5'd0;
        tick;
        chk("pipe0_we", {31'd0, rf_we}, 32'd0);
        chk("pipe0_hold", {27'd0, rf_addr}, 32'd8);

        // Long-unit results for $0 must never occupy the FIFO
        pipe_addr = 5'd30; pipe_data = 32'h30;
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hBAD;
        tick;
        chk_rf("pipe30", 5'd30, 32'h30);
        pipe_addr = 5'd31; pipe_data = 32'h31;
        tick;
        pipe_we = 1'b0; lu_valid = 1'b0;
        #1;
        chk("lu0_ready", {31'd0, lu_ready}, 32'd1);
        tick;
        chk("lu0_nowrite", {31'd0, rf_we}, 32'd0);

        // Single long-unit result while the pipe is idle
        lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h11; chk_addr = 5'd3;
        #1;
        chk("lu3_ready", {31'd0, lu_ready}, 32'd1);
        chk("lu3_pend_samecyc", {31'd0, chk_pending}, 32'd0);
        tick;
        lu_valid = 1'b0;
        #1;
        chk("lu3_pend", {31'd0, chk_pending}, 32'd1);
        chk("lu3_we_early", {31'd0, rf_we}, 32'd0);
        tick;
        chk_rf("lu3_wr", 5'd3, 32'h11);
        chk("lu3_pend_after", {31'd0, chk_pending}, 32'd0);

        // Fill FIFO under continuous pipe traffic; forced drain after 4 deferrals
        pipe_we = 1'b1; pipe_addr = 5'd10; pipe_data = 32'hA0;
        lu_valid = 1'b1; lu_addr = 5'd4; lu_data = 32'h44; chk_addr = 5'd4;
        #1 chk("fill_ready0", {31'd0, lu_ready}, 32'd1);
        tick;
        chk_rf("fill_p10", 5'd10, 32'hA0);
        pipe_addr = 5'd11; pipe_data = 32'hA1; lu_addr = 5'd5; lu_data = 32'h55;
        #1 chk("fill_ready1", {31'd0, lu_ready}, 32'd1);
        tick;
        chk_rf("fill_p11", 5'd11, 32'hA1);
        lu_valid = 1'b0; pipe_addr = 5'd12; pipe_data = 32'hA2;
        #1;
        chk("full_ready", {31'd0, lu_ready}, 32'd0);
        chk("full_pend4", {31'd0, chk_pending}, 32'd1);
        chk("defer2_stall", {31'd0, pipe_stall}, 32'd0);
        tick;
        chk_rf("fill_p12", 5'd12, 32'hA2);
        pipe_addr = 5'd13; pipe_data = 32'hA3;
        #1 chk("defer3_stall", {31'd0, pipe_stall}, 32'd0);
        tick;
        chk_rf("fill_p13", 5'd13, 32'hA3);
        pipe_addr = 5'd14; pipe_data = 32'hA4;
        #1 chk("defer4_stall", {31'd0, pipe_stall}, 32'd0);
        tick;
        chk_rf("fill_p14", 5'd14, 32'hA4);
        pipe_addr = 5'd15; pipe_data = 32'hA5;
        #1 chk("drain1_stall", {31'd0, pipe_stall}, 32'd1);
        tick;
        chk_rf("drain1_wr4", 5'd4, 32'h44);
        chk("drain1_pend4", {31'd0, chk_pending}, 32'd0);
        chk("resume_stall", {31'd0, pipe_stall}, 32'd0);
        tick;
        chk_rf("resume_p15", 5'd15, 32'hA5);
        pipe_addr = 5'd16; pipe_data = 32'hA6;
        tick;
        pipe_addr = 5'd17; pipe_data = 32'hA7;
        tick;
        pipe_addr = 5'd18; pipe_data = 32'hA8;
        #1 chk("redefer_stall", {31'd0, pipe_stall}, 32'd0);
        tick;
        chk_rf("redefer_p18", 5'd18, 32'hA8);
        #1 chk("drain2_stall", {31'd0, pipe_stall}, 32'd1);
        tick;
        chk_rf("drain2_wr5", 5'd5, 32'h55);
        tick;
        chk_rf("retry_p18", 5'd18, 32'hA8);
        pipe_we = 1'b0;
        tick;
        chk("idle_we", {31'd0, rf_we}, 32'd0);

        // WAW squash of a queued entry by a later pipe write
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hAA; chk_addr = 5'd7;
        tick;
        lu_valid = 1'b0;
        pipe_we = 1'b1; pipe_addr = 5'd7; pipe_data = 32'hBB;
        #1 chk("waw_pend_before", {31'd0, chk_pending}, 32'd1);
        tick;
        chk_rf("waw_pipe7", 5'd7, 32'hBB);
        pipe_we = 1'b0;
        #1 chk("waw_pend_after", {31'd0, chk_pending}, 32'd0);
        tick;
        chk("waw_dead_pop_we", {31'd0, rf_we}, 32'd0);
        chk("waw_ready", {31'd0, lu_ready}, 32'd1);

        // Simultaneous push and pipe grant to the same register
        pipe_we = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h900D;
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'hBAD9; chk_addr = 5'd9;
        #1 chk("same_pend_samecyc", {31'd0, chk_pending}, 32'd0);
        tick;
        chk_rf("same_pipe9", 5'd9, 32'h900D);
        pipe_we = 1'b0; lu_valid = 1'b0;
        #1 chk("same_pend_dead", {31'd0, chk_pending}, 32'd0);
        tick;
        chk("same_dead_pop_we", {31'd0, rf_we}, 32'd0);
        tick;
        chk("same_idle_we", {31'd0, rf_we}, 32'd0);

        // Asynchronous reset while DRAIN is active with two queued entries
        pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h20;
        lu_valid = 1'b1; lu_addr = 5'd21; lu_data = 32'h21; chk_addr = 5'd21;
        tick;
        pipe_addr = 5'd22; lu_addr = 5'd23; lu_data = 32'h23;
        tick;
        lu_valid = 1'b0; pipe_addr = 5'd24;
        tick;
        pipe_addr = 5'd25;
        tick;
        pipe_addr = 5'd26;
        tick;
        #1;
        chk("pre_rst_stall", {31'd0, pipe_stall}, 32'd1);
        chk("pre_rst_ready", {31'd0, lu_ready}, 32'd0);
        chk("pre_rst_pend", {31'd0, chk_pending}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_we", {31'd0, rf_we}, 32'd0);
        chk("arst_addr", {27'd0, rf_addr}, 32'd0);
        chk("arst_data", rf_data, 32'd0);
        chk("arst_stall", {31'd0, pipe_stall}, 32'd0);
        chk("arst_ready", {31'd0, lu_ready}, 32'd1);
        chk("arst_pend", {31'd0, chk_pending}, 32'd0);
        pipe_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("post_rst_we", {31'd0, rf_we}, 32'd0);
        end
        chk_addr = 5'd23;
        #1 chk("post_rst_pend23", {31'd0, chk_pending}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
